// File: rtl/ch376_pkg.sv
// Shared definitions for the CH376 parallel-bus sequencer: state encoding,
// default bus phase lengths and the phase-counter reload helper.
package ch376_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_STROBE = 3'd2,
    ST_HOLD   = 3'd3,
    ST_DONE   = 3'd4
  } seq_state_t;

  localparam logic [7:0] DEF_BASE_PORT  = 8'h10;
  localparam int         DEF_SETUP_CYC  = 1;
  localparam int         DEF_STROBE_CYC = 4;
  localparam int         DEF_HOLD_CYC   = 2;

  // A phase of N cycles counts down from N-1 to 0, so it never wraps.
  function automatic logic [2:0] phase_load(input int cyc);
    return 3'(cyc - 1);
  endfunction

endpackage

// File: rtl/ch376_bus_sequencer_if.sv
// Z80 I/O bus and CH376 parallel-bus signals handled by the sequencer.
interface ch376_bus_sequencer_if;

  logic [7:0] z80_addr;
  logic       z80_iorq_n;
  logic       z80_rd_n;
  logic       z80_wr_n;
  logic [7:0] z80_din;
  logic [7:0] z80_dout;
  logic       z80_busdir;
  logic       z80_wait_n;
  logic       ch_cs_n;
  logic       ch_rd_n;
  logic       ch_wr_n;
  logic       ch_a0;
  logic [7:0] ch_dout;
  logic       ch_doe;
  logic [7:0] ch_din;

  modport slave (
    input  z80_addr, z80_iorq_n, z80_rd_n, z80_wr_n, z80_din, ch_din,
    output z80_dout, z80_busdir, z80_wait_n,
           ch_cs_n, ch_rd_n, ch_wr_n, ch_a0, ch_dout, ch_doe
  );

  modport master (
    output z80_addr, z80_iorq_n, z80_rd_n, z80_wr_n, z80_din, ch_din,
    input  z80_dout, z80_busdir, z80_wait_n,
           ch_cs_n, ch_rd_n, ch_wr_n, ch_a0, ch_dout, ch_doe
  );

endinterface

// File: rtl/sync2.sv
// Two-flop synchronizer for one asynchronous Z80 strobe; reset parks it at
// the inactive (high) level.
module sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/ch376_bus_sequencer.sv
// Turns one Z80 I/O cycle on BASE_PORT/BASE_PORT+1 into exactly one timed
// CH376 bus access, stretching the Z80 with WAIT until the access is done.
module ch376_bus_sequencer
  import ch376_pkg::*;
#(
  parameter logic [7:0] BASE_PORT  = DEF_BASE_PORT,
  parameter int         SETUP_CYC  = DEF_SETUP_CYC,
  parameter int         STROBE_CYC = DEF_STROBE_CYC,
  parameter int         HOLD_CYC   = DEF_HOLD_CYC
) (
  input logic                   clk,
  input logic                   reset,
  ch376_bus_sequencer_if.slave  bus
);

  localparam logic [2:0] SETUP_LOAD  = phase_load(SETUP_CYC);
  localparam logic [2:0] STROBE_LOAD = phase_load(STROBE_CYC);
  localparam logic [2:0] HOLD_LOAD   = phase_load(HOLD_CYC);

  logic       iorq_s, rd_s, wr_s;
  logic       port_hit, req, take_req, phase_last, in_access;
  seq_state_t state, state_next;
  logic [2:0] phase_cnt, phase_next;
  logic       is_write;
  logic       ch_a0_q;
  logic [7:0] ch_dout_q, z80_dout_q;

  sync2 u_sync_iorq (.clk(clk), .reset(reset), .d(bus.z80_iorq_n), .q(iorq_s));
  sync2 u_sync_rd   (.clk(clk), .reset(reset), .d(bus.z80_rd_n),   .q(rd_s));
  sync2 u_sync_wr   (.clk(clk), .reset(reset), .d(bus.z80_wr_n),   .q(wr_s));

  // Both rd_n and wr_n low is a malformed cycle and is ignored.
  assign port_hit   = (bus.z80_addr[7:1] == BASE_PORT[7:1]);
  assign req        = !iorq_s && (rd_s != wr_s) && port_hit;
  assign take_req   = (state == ST_IDLE) && req && !reset;
  assign phase_last = (phase_cnt == 3'd0);
  assign in_access  = (state == ST_SETUP) || (state == ST_STROBE) || (state == ST_HOLD);

  always_comb begin
    state_next = state;
    phase_next = phase_cnt;
    case (state)
      ST_IDLE: begin
        if (req) begin
          state_next = ST_SETUP;
          phase_next = SETUP_LOAD;
        end
      end
      ST_SETUP: begin
        if (phase_last) begin
          state_next = ST_STROBE;
          phase_next = STROBE_LOAD;
        end else begin
          phase_next = phase_cnt - 3'd1;
        end
      end
      ST_STROBE: begin
        if (phase_last) begin
          state_next = ST_HOLD;
          phase_next = HOLD_LOAD;
        end else begin
          phase_next = phase_cnt - 3'd1;
        end
      end
      ST_HOLD: begin
        if (phase_last) begin
          state_next = ST_DONE;
          phase_next = 3'd0;
        end else begin
          phase_next = phase_cnt - 3'd1;
        end
      end
      ST_DONE: begin
        // Waiting for the Z80 to end its cycle guarantees one access per cycle.
        if (iorq_s) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
        phase_next = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      phase_cnt  <= 3'd0;
      is_write   <= 1'b0;
      ch_a0_q    <= 1'b0;
      ch_dout_q  <= 8'h00;
      z80_dout_q <= 8'h00;
    end else begin
      state     <= state_next;
      phase_cnt <= phase_next;
      if (take_req) begin
        ch_a0_q  <= bus.z80_addr[0];
        is_write <= !wr_s;
        if (!wr_s) begin
          ch_dout_q <= bus.z80_din;
        end
      end
      if ((state == ST_STROBE) && phase_last && !is_write) begin
        z80_dout_q <= bus.ch_din;
      end
    end
  end

  // WAIT and chip select assert already in the cycle the request is seen.
  assign bus.z80_wait_n = !(in_access || take_req);
  assign bus.ch_cs_n    = !(in_access || take_req);
  assign bus.ch_rd_n    = !((state == ST_STROBE) && !is_write);
  assign bus.ch_wr_n    = !((state == ST_STROBE) && is_write);
  assign bus.ch_doe     = in_access && is_write;
  assign bus.ch_a0      = ch_a0_q;
  assign bus.ch_dout    = ch_dout_q;
  assign bus.z80_dout   = z80_dout_q;
  assign bus.z80_busdir = !bus.z80_iorq_n && !bus.z80_rd_n && port_hit;

endmodule

// File: tb/tb_ch376_bus_sequencer.sv
// Self-checking bench for ch376_bus_sequencer: directed scenarios plus random
// Z80 cycles compared against a transaction-level model of the bus rules.
module tb_ch376_bus_sequencer;

  localparam int         S    = 1;
  localparam int         T    = 4;
  localparam int         H    = 2;
  localparam logic [7:0] BASE = 8'h10;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  ch376_bus_sequencer_if bus();

  ch376_bus_sequencer #(
    .BASE_PORT (BASE),
    .SETUP_CYC (S),
    .STROBE_CYC(T),
    .HOLD_CYC  (H)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int         vectors = 0;
  int         miscompares = 0;
  int         rd_low, wr_low, wait_low, doe_high, pulses;
  logic       seen_a0;
  logic [7:0] seen_dout;
  logic       prev_idle = 1'b1;
  logic [7:0] model_dout = 8'h00;

  // Observer: tallies CH376 strobe activity per transaction on the falling edge.
  always @(negedge clk) begin
    if (!bus.ch_rd_n) rd_low++;
    if (!bus.ch_wr_n) begin
      wr_low++;
      seen_dout = bus.ch_dout;
    end
    if (!bus.z80_wait_n) wait_low++;
    if (bus.ch_doe) doe_high++;
    if (!bus.ch_rd_n || !bus.ch_wr_n) seen_a0 = bus.ch_a0;
    if (prev_idle && !(bus.ch_rd_n && bus.ch_wr_n)) pulses++;
    prev_idle = bus.ch_rd_n && bus.ch_wr_n;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout got running want finished");
    $fatal(1, "[TB] simulation time limit");
  end

  function automatic bit model_access(input logic [7:0] addr, input bit rd, input bit wr);
    return (addr[7:1] == BASE[7:1]) && (rd != wr);
  endfunction

  task automatic drive_access(input logic [7:0] addr, input bit rd, input bit wr,
                              input logic [7:0] din, input logic [7:0] chdin,
                              input int hold, output logic busdir_seen);
    @(posedge clk);
    #1;
    rd_low = 0; wr_low = 0; wait_low = 0; doe_high = 0; pulses = 0;
    seen_a0 = 1'bx; seen_dout = 8'hxx;
    bus.ch_din     = chdin;
    bus.z80_addr   = addr;
    bus.z80_din    = din;
    bus.z80_iorq_n = 1'b0;
    bus.z80_rd_n   = !rd;
    bus.z80_wr_n   = !wr;
    #1 busdir_seen = bus.z80_busdir;
    repeat (hold) @(posedge clk);
    #1;
    bus.z80_iorq_n = 1'b1;
    bus.z80_rd_n   = 1'b1;
    bus.z80_wr_n   = 1'b1;
    repeat (16) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    vectors++; if (bus.ch_cs_n !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_cs_n got %b want 1", bus.ch_cs_n); end
    vectors++; if (bus.ch_rd_n !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_rd_n got %b want 1", bus.ch_rd_n); end
    vectors++; if (bus.ch_wr_n !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_wr_n got %b want 1", bus.ch_wr_n); end
    vectors++; if (bus.ch_doe !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_doe got %b want 0", bus.ch_doe); end
    vectors++; if (bus.ch_a0 !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_a0 got %b want 0", bus.ch_a0); end
    vectors++; if (bus.ch_dout !== 8'h00) begin miscompares++; $display("[TB] FAIL reset_ch_dout got %h want 00", bus.ch_dout); end
    vectors++; if (bus.z80_dout !== 8'h00) begin miscompares++; $display("[TB] FAIL reset_z80_dout got %h want 00", bus.z80_dout); end
    vectors++; if (bus.z80_wait_n !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_wait_n got %b want 1", bus.z80_wait_n); end
    reset = 1'b0;
  endtask

  task automatic test_read();
    logic bd;
    drive_access(8'h10, 1'b1, 1'b0, 8'h00, 8'hA5, 20, bd);
    model_dout = 8'hA5;
    vectors++; if (pulses !== 1) begin miscompares++; $display("[TB] FAIL read_pulses got %0d want 1", pulses); end
    vectors++; if (rd_low !== T) begin miscompares++; $display("[TB] FAIL read_rd_low got %0d want %0d", rd_low, T); end
    vectors++; if (wr_low !== 0) begin miscompares++; $display("[TB] FAIL read_wr_low got %0d want 0", wr_low); end
    vectors++; if (wait_low !== 1 + S + T + H) begin miscompares++; $display("[TB] FAIL read_wait_low got %0d want %0d", wait_low, 1 + S + T + H); end
    vectors++; if (seen_a0 !== 1'b0) begin miscompares++; $display("[TB] FAIL read_a0 got %b want 0", seen_a0); end
    vectors++; if (bus.z80_dout !== model_dout) begin miscompares++; $display("[TB] FAIL read_dout got %h want %h", bus.z80_dout, model_dout); end
    vectors++; if (bd !== 1'b1) begin miscompares++; $display("[TB] FAIL read_busdir got %b want 1", bd); end
  endtask

  task automatic test_write();
    logic bd;
    drive_access(8'h11, 1'b0, 1'b1, 8'h06, 8'hFF, 20, bd);
    vectors++; if (pulses !== 1) begin miscompares++; $display("[TB] FAIL write_pulses got %0d want 1", pulses); end
    vectors++; if (wr_low !== T) begin miscompares++; $display("[TB] FAIL write_wr_low got %0d want %0d", wr_low, T); end
    vectors++; if (rd_low !== 0) begin miscompares++; $display("[TB] FAIL write_rd_low got %0d want 0", rd_low); end
    vectors++; if (doe_high !== S + T + H) begin miscompares++; $display("[TB] FAIL write_doe got %0d want %0d", doe_high, S + T + H); end
    vectors++; if (seen_a0 !== 1'b1) begin miscompares++; $display("[TB] FAIL write_a0 got %b want 1", seen_a0); end
    vectors++; if (seen_dout !== 8'h06) begin miscompares++; $display("[TB] FAIL write_ch_dout got %h want 06", seen_dout); end
    vectors++; if (bus.z80_dout !== model_dout) begin miscompares++; $display("[TB] FAIL write_z80_dout got %h want %h", bus.z80_dout, model_dout); end
    vectors++; if (bd !== 1'b0) begin miscompares++; $display("[TB] FAIL write_busdir got %b want 0", bd); end
  endtask

  task automatic test_port_decode();
    logic bd;
    drive_access(8'h12, 1'b1, 1'b0, 8'h00, 8'h77, 20, bd);
    vectors++; if (pulses !== 0) begin miscompares++; $display("[TB] FAIL nomatch_pulses got %0d want 0", pulses); end
    vectors++; if (wait_low !== 0) begin miscompares++; $display("[TB] FAIL nomatch_wait got %0d want 0", wait_low); end
    vectors++; if (bd !== 1'b0) begin miscompares++; $display("[TB] FAIL nomatch_busdir got %b want 0", bd); end
    vectors++; if (bus.z80_dout !== model_dout) begin miscompares++; $display("[TB] FAIL nomatch_dout got %h want %h", bus.z80_dout, model_dout); end
    drive_access(8'h11, 1'b1, 1'b0, 8'h00, 8'h3C, 20, bd);
    model_dout = 8'h3C;
    vectors++; if (bd !== 1'b1) begin miscompares++; $display("[TB] FAIL cmdport_busdir got %b want 1", bd); end
    vectors++; if (bus.z80_dout !== model_dout) begin miscompares++; $display("[TB] FAIL cmdport_dout got %h want %h", bus.z80_dout, model_dout); end
  endtask

  task automatic test_both_low();
    logic bd;
    drive_access(8'h10, 1'b1, 1'b1, 8'h55, 8'h99, 20, bd);
    vectors++; if (pulses !== 0) begin miscompares++; $display("[TB] FAIL bothlow_pulses got %0d want 0", pulses); end
    vectors++; if (wait_low !== 0) begin miscompares++; $display("[TB] FAIL bothlow_wait got %0d want 0", wait_low); end
    vectors++; if (bus.z80_dout !== model_dout) begin miscompares++; $display("[TB] FAIL bothlow_dout got %h want %h", bus.z80_dout, model_dout); end
  endtask

  task automatic test_early_release();
    logic bd;
    drive_access(8'h10, 1'b1, 1'b0, 8'h00, 8'hC3, 3, bd);
    model_dout = 8'hC3;
    vectors++; if (pulses !== 1) begin miscompares++; $display("[TB] FAIL early_pulses got %0d want 1", pulses); end
    vectors++; if (rd_low !== T) begin miscompares++; $display("[TB] FAIL early_rd_low got %0d want %0d", rd_low, T); end
    vectors++; if (wait_low !== 1 + S + T + H) begin miscompares++; $display("[TB] FAIL early_wait got %0d want %0d", wait_low, 1 + S + T + H); end
    vectors++; if (bus.z80_dout !== model_dout) begin miscompares++; $display("[TB] FAIL early_dout got %h want %h", bus.z80_dout, model_dout); end
    vectors++; if (bus.ch_cs_n !== 1'b1) begin miscompares++; $display("[TB] FAIL early_idle_cs got %b want 1", bus.ch_cs_n); end
  endtask

  task automatic test_reset_mid_strobe();
    int guard;
    @(posedge clk);
    #1;
    bus.ch_din     = 8'h5A;
    bus.z80_addr   = 8'h10;
    bus.z80_iorq_n = 1'b0;
    bus.z80_rd_n   = 1'b0;
    bus.z80_wr_n   = 1'b1;
    guard = 0;
    @(negedge clk);
    while (bus.ch_rd_n && guard < 30) begin
      @(negedge clk);
      guard++;
    end
    vectors++; if (bus.ch_rd_n !== 1'b0) begin miscompares++; $display("[TB] FAIL midstrobe_reach got rd_n=%b want 0 within 30 cycles", bus.ch_rd_n); end
    reset          = 1'b1;
    bus.z80_iorq_n = 1'b1;
    bus.z80_rd_n   = 1'b1;
    @(posedge clk);
    #1;
    model_dout = 8'h00;
    vectors++; if (bus.ch_rd_n !== 1'b1) begin miscompares++; $display("[TB] FAIL midreset_rd_n got %b want 1", bus.ch_rd_n); end
    vectors++; if (bus.ch_cs_n !== 1'b1) begin miscompares++; $display("[TB] FAIL midreset_cs_n got %b want 1", bus.ch_cs_n); end
    vectors++; if (bus.z80_wait_n !== 1'b1) begin miscompares++; $display("[TB] FAIL midreset_wait_n got %b want 1", bus.z80_wait_n); end
    vectors++; if (bus.ch_dout !== 8'h00) begin miscompares++; $display("[TB] FAIL midreset_ch_dout got %h want 00", bus.ch_dout); end
    vectors++; if (bus.z80_dout !== model_dout) begin miscompares++; $display("[TB] FAIL midreset_z80_dout got %h want %h", bus.z80_dout, model_dout); end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    pulses = 0; wait_low = 0;
    repeat (20) @(posedge clk);
    #1;
    vectors++; if (pulses !== 0) begin miscompares++; $display("[TB] FAIL postreset_pulses got %0d want 0", pulses); end
    vectors++; if (wait_low !== 0) begin miscompares++; $display("[TB] FAIL postreset_wait got %0d want 0", wait_low); end
  endtask

  task automatic test_random();
    logic [7:0] addr, din, chdin;
    bit         rd, wr, valid;
    int         kind, hold;
    logic       bd;
    for (int it = 0; it < 24; it++) begin
      kind  = $urandom_range(0, 5);
      din   = 8'($urandom_range(0, 255));
      chdin = 8'($urandom_range(0, 255));
      hold  = ($urandom_range(0, 1) == 1) ? 20 : 3;
      addr  = BASE | 8'($urandom_range(0, 1));
      rd    = (kind <= 1) || (kind == 5);
      wr    = (kind == 2) || (kind == 3) || (kind == 5);
      if (kind == 4) begin
        addr = 8'($urandom_range(0, 255));
        if (addr[7:1] == BASE[7:1]) addr = addr ^ 8'h40;
        rd = ($urandom_range(0, 1) == 1);
        wr = !rd;
      end
      valid = model_access(addr, rd, wr);
      drive_access(addr, rd, wr, din, chdin, hold, bd);
      if (valid && rd) model_dout = chdin;
      vectors++; if (pulses !== (valid ? 1 : 0)) begin miscompares++; $display("[TB] FAIL rand%0d_pulses got %0d want %0d", it, pulses, valid ? 1 : 0); end
      vectors++; if (rd_low !== ((valid && rd) ? T : 0)) begin miscompares++; $display("[TB] FAIL rand%0d_rd_low got %0d want %0d", it, rd_low, (valid && rd) ? T : 0); end
      vectors++; if (wr_low !== ((valid && wr) ? T : 0)) begin miscompares++; $display("[TB] FAIL rand%0d_wr_low got %0d want %0d", it, wr_low, (valid && wr) ? T : 0); end
      vectors++; if (wait_low !== (valid ? 1 + S + T + H : 0)) begin miscompares++; $display("[TB] FAIL rand%0d_wait got %0d want %0d", it, wait_low, valid ? 1 + S + T + H : 0); end
      vectors++; if (bd !== (rd && (addr[7:1] == BASE[7:1]))) begin miscompares++; $display("[TB] FAIL rand%0d_busdir got %b want %b", it, bd, rd && (addr[7:1] == BASE[7:1])); end
      vectors++; if (bus.z80_dout !== model_dout) begin miscompares++; $display("[TB] FAIL rand%0d_dout got %h want %h", it, bus.z80_dout, model_dout); end
      if (valid) begin
        vectors++; if (seen_a0 !== addr[0]) begin miscompares++; $display("[TB] FAIL rand%0d_a0 got %b want %b", it, seen_a0, addr[0]); end
      end
      if (valid && wr) begin
        vectors++; if (seen_dout !== din) begin miscompares++; $display("[TB] FAIL rand%0d_ch_dout got %h want %h", it, seen_dout, din); end
      end
    end
  endtask

  initial begin
    bus.z80_addr   = 8'h00;
    bus.z80_iorq_n = 1'b1;
    bus.z80_rd_n   = 1'b1;
    bus.z80_wr_n   = 1'b1;
    bus.z80_din    = 8'h00;
    bus.ch_din     = 8'h00;
    test_reset();
    test_read();
    test_write();
    test_port_decode();
    test_both_low();
    test_early_release();
    test_reset_mid_strobe();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ch376_bus_sequencer.md
CH376_BUS_SEQUENCER -- requirements
Module: ch376_bus_sequencer

Interface
REQ-001 SHALL have parameter BASE_PORT, default 8'h10, meaning the data port address; BASE_PORT+1 is the command/status port.
REQ-002 SHALL have parameters SETUP_CYC=1, STROBE_CYC=4, HOLD_CYC=2, meaning the clk cycles per CH376 bus phase, each in the range 1..7.
REQ-003 SHALL use one clock and a synchronous, active-high reset; all state is updated on the rising edge of clk.
REQ-004 SHALL have ports, as name  direction  width  meaning:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- z80_addr  in  8  Z80 I/O address (A7..A0)
- z80_iorq_n, z80_rd_n, z80_wr_n  in  1 each  Z80 strobes, asynchronous
- z80_din  in  8  Z80 write data
- z80_dout  out  8  read data returned to Z80
- z80_busdir  out  1  high means the cartridge drives the data bus
- z80_wait_n  out  1  Z80 WAIT, active low
- ch_cs_n, ch_rd_n, ch_wr_n  out  1 each  CH376 strobes
- ch_a0  out  1  CH376 A0 (0 = data, 1 = command)
- ch_dout  out  8  data to CH376
- ch_doe  out  1  ch_dout output enable
- ch_din  in  8  data from CH376

Function
REQ-005 SHALL pass z80_iorq_n, z80_rd_n and z80_wr_n through a 2-flop synchronizer each; z80_addr and z80_din are sampled only when a request is detected.
REQ-006 SHALL define a request as: synchronized iorq_n=0, exactly one of synchronized rd_n/wr_n =0, and z80_addr[7:1]==BASE_PORT[7:1].
- If both rd_n and wr_n are low, it is not a request.
REQ-007 SHALL have the states IDLE, SETUP, STROBE, HOLD and DONE.
REQ-008 IDLE->SETUP SHALL occur in the cycle a request is seen.
- On that edge, latch ch_a0=z80_addr[0], the direction (read/write) and, for writes, z80_din into ch_dout.
- Drive z80_wait_n=0 and ch_cs_n=0.
REQ-009 SETUP SHALL last SETUP_CYC cycles with ch_cs_n=0, strobes high and ch_doe=1 for writes; SETUP->STROBE.
REQ-010 STROBE SHALL last STROBE_CYC cycles with ch_rd_n=0 (read) or ch_wr_n=0 (write).
- For reads, the edge leaving STROBE loads ch_din into z80_dout.
- STROBE->HOLD.
REQ-011 HOLD SHALL last HOLD_CYC cycles with strobes high, ch_cs_n=0 and ch_doe held for writes; HOLD->DONE.
REQ-012 In DONE: ch_cs_n=1, ch_doe=0, z80_wait_n=1.
- Stay in DONE while synchronized iorq_n=0; go to IDLE the first cycle it reads 1.
- One Z80 cycle yields exactly one CH376 access.
REQ-013 SHALL use a phase counter of 3 bits, reloaded on every state entry; the counter shall never wrap.
REQ-014 z80_busdir SHALL be combinational: 1 iff raw z80_iorq_n=0, z80_rd_n=0 and z80_addr[7:1]==BASE_PORT[7:1].
REQ-015 z80_dout SHALL hold the last captured byte until the next read capture.
REQ-016 If iorq_n rises before DONE, SHALL complete the CH376 access unchanged, then pass through DONE to IDLE in one cycle.
REQ-017 Accesses to non-matching ports SHALL leave every output except z80_busdir unchanged.

Reset
REQ-018 Reset SHALL force, on the next edge and from any state including mid-strobe:
- state=IDLE
- ch_cs_n=ch_rd_n=ch_wr_n=1, ch_doe=0, ch_a0=0, ch_dout=8'h00
- z80_dout=8'h00, z80_wait_n=1
- synchronizers set to 1
REQ-019 Reset SHALL take priority over any request present in the same cycle.

Structure
REQ-020 SHALL place the state encoding and the default phase lengths in a shared package, ch376_pkg.
REQ-021 SHALL implement the 2-flop synchronizer as the sub-module sync2, instantiated once per strobe.

Verification
REQ-022 The bench SHALL cover:
- Read, port 0x10, ch_din=8'hA5 -> ch_a0=0, ch_rd_n low exactly 4 cycles, z80_dout=8'hA5, z80_wait_n low for 1+4+2+1 cycles after detection.
- Write, port 0x11, z80_din=8'h06 -> ch_a0=1, ch_dout=8'h06, ch_doe=1 through SETUP/STROBE/HOLD, ch_wr_n low 4 cycles, ch_rd_n stays 1.
- Read, port 0x12 -> no CH376 strobe, z80_wait_n stays 1, z80_busdir=0; port 0x11 with rd_n=0 -> z80_busdir=1.
- Reset asserted during STROBE -> next edge ch_rd_n=1, ch_cs_n=1, z80_wait_n=1, state IDLE; no spurious second access after release.
- iorq_n held low 20 cycles -> exactly one strobe; iorq_n released during SETUP -> full access, then IDLE.
- rd_n and wr_n low together, port 0x10 -> no access.
